sr_latch_ctrl: RTL
==================

# sr_latch_ctrl

Synchronous controller that owns the S/R inputs of a shared SR latch and schedules set/reset commands from N_REQ requesters. It grants one request at a time in round-robin order and drives a clean S or R pulse of programmed width. Every pulse is followed by a guard gap with S=R=0, and the controller then checks the latch Q feedback against the commanded value. The latch's forbidden S=R=1 input is never presented, and S and R never switch into each other without a gap.

## Interface
- N_REQ, 4: number of requesters; power of two, ≥2.
- PULSE_CYC, 2: cycles S or R is held high per command; ≥1.
- GAP_CYC, 1: cycles S=R=0 after each pulse before Q is checked; ≥1.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_set  in  N_REQ  level request per requester to drive latch Q to 1.
- req_rst  in  N_REQ  level request per requester to drive latch Q to 0.
- q_fb  in  1  Q output of the controlled latch.
- S  out  1  latch set drive, registered.
- R  out  1  latch reset drive, registered.
- grant  out  N_REQ  one-hot, 1-cycle pulse identifying the accepted requester.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  1-cycle pulse: command completed and q_fb matched.
- fail  out  1  1-cycle pulse: command completed and q_fb mismatched.
- err  out  1  1-cycle pulse: some requester had req_set and req_rst both high while sampled in IDLE.

## Operation
- States:
  - IDLE
  - PULSE: counts PULSE_CYC.
  - GAP: counts GAP_CYC.
- Internal registers:
  - ptr: round-robin pointer, $clog2(N_REQ) bits, wraps N_REQ-1→0.
  - op: 1 means set, 0 means reset.
  - cnt: sized $clog2(max(PULSE_CYC,GAP_CYC)+1).
- Valid request from requester i: req_set[i] XOR req_rst[i]. A requester with both bits high is invalid. It is excluded from arbitration, and err pulses on the next cycle.
- IDLE with at least one valid request:
  - Select the first valid index scanning ptr, ptr+1, … with wrap.
  - Next cycle: grant[i]=1, op=req_set[i], S=op, R=!op, ptr=i+1 mod N_REQ, cnt loaded, state PULSE.
- IDLE with no valid request: stay in IDLE, ptr unchanged.
- PULSE: hold S/R for PULSE_CYC cycles total, then S=R=0 and go to GAP.
- GAP:
  - Hold S=R=0 for GAP_CYC cycles.
  - Sample q_fb on the last GAP cycle.
  - Next cycle: done=(q_fb==op), fail=!done, state IDLE.
- Requesters must deassert the granted request no later than the cycle after grant. Non-granted requests stay pending, since they are level-held.
- Invariants: S&R never 1; S and R are both 0 in IDLE and GAP; exactly one of done/fail per granted command (except on reset).
- Reset values: state IDLE; S, R, grant, busy, done, fail, err, ptr and cnt all 0.
- Reset mid-operation: S/R drop to 0 at the next edge. No done/fail is issued, ptr returns to 0, and the pending command is discarded.

## Timing
- Request sampled in IDLE at cycle t.
- grant, busy and the S or R pulse start at t+1.
- The pulse occupies t+1 … t+PULSE_CYC.
- The gap occupies t+PULSE_CYC+1 … t+PULSE_CYC+GAP_CYC.
- done/fail and the return to IDLE (busy=0) occur at t+PULSE_CYC+GAP_CYC+1. A new request can be sampled in that same cycle.
- Back-to-back command period is PULSE_CYC+GAP_CYC+1 cycles (4 at defaults).
- err is asserted at t+1 for a conflict sampled at t. It can coincide with grant for a different requester.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
The bench models the latch behaviorally, with q_fb = Q. Defaults apply: N_REQ=4, PULSE_CYC=2, GAP_CYC=1.
- Reset: rst=1 for 2 cycles with random requests → S=R=grant=busy=done=fail=err=0, and the next grant search starts at index 0.
- Single set: req_set=4'b0100 at t → grant=0100 at t+1; S=1 at t+1..t+2; S=R=0 at t+3; done=1 and busy=0 at t+4; q_fb=1.
- Contention/round-robin: req_set=0001 and req_rst=0010 held until granted, ptr=0 → requester 0 is granted at t+1 (S pulse), requester 1 at t+5 (R pulse), then ptr=2. S and R are never simultaneously or adjacently high without a gap cycle.
- Conflict: req_set[3]=req_rst[3]=1 only → err=1 at t+1 with no grant and S=R=0. Adding req_rst[1]=1 → grant=0010 and err at the same cycle.
- Feedback mismatch: q_fb forced to 0 with a set request at t → fail=1 and done=0 at t+4.
- Reset mid-pulse: set granted at t+1, rst=1 at t+2 → S=0 at t+3, no done/fail, busy=0, ptr=0.

Source files
------------

// File: rtl/sr_latch_ctrl_if.sv
// Request/feedback and drive bundle between requesters and the SR latch controller.
interface sr_latch_ctrl_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req_set;
    logic [N_REQ-1:0] req_rst;
    logic             q_fb;
    logic             S;
    logic             R;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic             done;
    logic             fail;
    logic             err;

    modport slave (
        input  req_set, req_rst, q_fb,
        output S, R, grant, busy, done, fail, err
    );

    modport master (
        output req_set, req_rst, q_fb,
        input  S, R, grant, busy, done, fail, err
    );
endinterface

// File: rtl/sr_latch_ctrl.sv
// Round-robin scheduler for set/reset commands on a shared SR latch:
// fixed-width S/R pulse, guard gap, then Q feedback check.
module sr_latch_ctrl #(
    parameter int N_REQ     = 4,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input logic             clk,
    input logic             rst,
    sr_latch_ctrl_if.slave  bus
);
    localparam int PW   = $clog2(N_REQ);
    localparam int MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic             op, op_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             s_q, s_n, r_q, r_n;
    logic [N_REQ-1:0] grant_q, grant_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n, fail_q, fail_n, err_q, err_n;

    logic [N_REQ-1:0] valid;
    logic [PW-1:0]    sel;
    logic             found;

    assign valid = bus.req_set ^ bus.req_rst;

    // First valid requester at or after ptr; pointer width makes the scan wrap.
    always_comb begin
        logic [PW-1:0] idx;
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + PW'(k);
            if (!found && valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        op_n    = op;
        cnt_n   = cnt;
        s_n     = s_q;
        r_n     = r_q;
        grant_n = '0;
        done_n  = 1'b0;
        fail_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                err_n = |(bus.req_set & bus.req_rst);
                if (found) begin
                    grant_n[sel] = 1'b1;
                    op_n         = bus.req_set[sel];
                    s_n          = bus.req_set[sel];
                    r_n          = ~bus.req_set[sel];
                    ptr_n        = sel + PW'(1);
                    cnt_n        = CW'(PULSE_CYC - 1);
                    state_n      = PULSE;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    s_n     = 1'b0;
                    r_n     = 1'b0;
                    cnt_n   = CW'(GAP_CYC - 1);
                    state_n = GAP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    done_n  = (bus.q_fb == op);
                    fail_n  = (bus.q_fb != op);
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                s_n     = 1'b0;
                r_n     = 1'b0;
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            op      <= 1'b0;
            cnt     <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            op      <= op_n;
            cnt     <= cnt_n;
            s_q     <= s_n;
            r_q     <= r_n;
            grant_q <= grant_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            fail_q  <= fail_n;
            err_q   <= err_n;
        end
    end

    assign bus.S     = s_q;
    assign bus.R     = r_q;
    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.fail  = fail_q;
    assign bus.err   = err_q;
endmodule
